rgb_hue_sequencer: RTL and testbench
====================================

# rgb_hue_sequencer

Upstream duty-cycle source for the RGB PWM path: sweeps a full colour wheel by ramping three duty words through six hue segments at a programmable step rate. Each `duty_*` output drives the `duty` input of one `pwm_enhanced` instance, one per LED channel. Replaces single-channel linear ramps with a coordinated three-channel sequence.

## Interface
- `R`, 8, PWM resolution in bits; `MAX = 2**R`
- `STEP_DIV`, 2499999, clocks per ramp step minus one (one step every `STEP_DIV+1` clocks)
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-high
- `en`  in  1  run enable; low freezes the sequence
- `restart`  in  1  synchronous one-cycle pulse; returns the sequence to segment 0, step 0
- `duty_r`  out  R+1  red duty word, 0..MAX
- `duty_g`  out  R+1  green duty word, 0..MAX
- `duty_b`  out  R+1  blue duty word, 0..MAX
- `segment`  out  3  current hue segment, 0..5
- `wrap`  out  1  one-cycle pulse when the wheel completes (segment 5 -> 0)

## Operation
- Prescaler `div_cnt` counts 0..STEP_DIV while `en`=1. It holds while `en`=0. `tick` is asserted when `div_cnt`==STEP_DIV and `en`=1; `div_cnt` then returns to 0.
- State: `seg` (0..5) and `v` (0..MAX-1).
- On `tick`:
  - if `v`<MAX-1, then `v`++;
  - otherwise `v`<=0 and `seg` advances; 5 wraps to 0.
- Segment map, with `up`=`v` and `dn`=MAX-`v`:
  - 0: R=MAX, G=up, B=0
  - 1: R=dn, G=MAX, B=0
  - 2: R=0, G=MAX, B=up
  - 3: R=0, G=dn, B=MAX
  - 4: R=up, G=0, B=MAX
  - 5: R=MAX, G=0, B=dn
- Each segment lasts MAX ticks; a full wheel is 6*MAX ticks. The colour is continuous across segment boundaries: the last step of a segment differs from the first step of the next by one LSB on one channel.
- `restart` clears `div_cnt`, `seg` and `v`. If `restart` and `tick` occur in the same cycle, `restart` wins. `restart` is honoured regardless of `en`.
- Arithmetic: `dn` is computed R+1 bits wide. No output ever exceeds MAX.

## Timing
- Output registers `duty_*`, `segment` and `wrap` load every clock from the current state. They lag `seg`/`v` by exactly one cycle.
- Reset values:
  - `duty_r`, `duty_g`, `duty_b` = 0
  - `segment` = 0
  - `wrap` = 0
  - internal `div_cnt`, `seg`, `v` = 0
- First rising edge after `rst` is released: `duty_r`=MAX, `duty_g`=0, `duty_b`=0. This happens regardless of `en`.
- With `en` held high, the first step appears on the outputs `STEP_DIV+2` clocks after reset release.
- `wrap` is high for exactly one cycle: the cycle in which `segment` first reads 0 after 5. It is not asserted on reset or on `restart`.
- Asserting `rst` mid-sequence clears all state and outputs immediately, with no clock required.
- When `en` falls, outputs freeze at their current value after at most one cycle. When `en` rises again, stepping resumes from the held `div_cnt`.

## Configuration
- `RGB_HUE_GAMMA_EN` defined:
  - each channel value `x` (0..MAX) is replaced by `(x*x)>>R` before registering;
  - the product is 2R+2 bits wide;
  - endpoints are preserved (0 -> 0, MAX -> MAX);
  - latency is unchanged (the square is combinational ahead of the output register).
- Undefined: channel values pass linearly; no multiplier is instantiated.

## Test plan
(R=4, STEP_DIV=3 → MAX=16, tick every 4 clocks)
- **Reset**: hold `rst`; release with `en`=0 → `duty_r`/`duty_g`/`duty_b`=0 during reset; after the first edge r=16, g=0, b=0, `segment`=0; outputs stay frozen while `en`=0.
- **Ramp/boundary**: `en`=1 → `duty_g`=1 at 5 clocks after release; after 15 ticks g=15; on the next tick `segment`=1, r=16, g=16; the tick after that, r=15.
- **Full wheel**: `en`=1 for 96 ticks → `wrap` high for exactly one cycle, with `segment`=0, r=16, g=0, b=0; `wrap` is low on every other cycle.
- **Freeze/restart**:
  - drop `en` mid-segment 2 → b holds its value; no step occurs while `en`=0; resume continues from the same value;
  - `restart` coincident with `tick` in segment 4 → next outputs are r=16, g=0, b=0, `segment`=0, and `wrap`=0.
- **Async reset**: assert `rst` asynchronously in segment 3 → all outputs read 0 before the next clock edge.
- **`RGB_HUE_GAMMA_EN`**:
  - segment 0 with `v`=8 → g=4; `v`=15 → g=14; r=16 throughout;
  - without the macro, the same points read g=8 and g=15.

Source files
------------

// File: rtl/rgb_hue_if.sv
// Control and duty-word bundle between a hue sequencer and its consumer.
// The slave side is the sequencer; the master side drives en/restart and reads the duty words.
interface rgb_hue_if #(
    parameter int R = 8
);
    logic         en;
    logic         restart;
    logic [R:0]   duty_r;
    logic [R:0]   duty_g;
    logic [R:0]   duty_b;
    logic [2:0]   segment;
    logic         wrap;

    modport master (
        output en,
        output restart,
        input  duty_r,
        input  duty_g,
        input  duty_b,
        input  segment,
        input  wrap
    );

    modport slave (
        input  en,
        input  restart,
        output duty_r,
        output duty_g,
        output duty_b,
        output segment,
        output wrap
    );
endinterface

// File: rtl/rgb_hue_sequencer.sv
// Six-segment colour-wheel generator producing three R+1 bit duty words for the RGB PWM path.
// Define RGB_HUE_GAMMA_EN to square each channel ((x*x)>>R) ahead of the output registers.
module rgb_hue_sequencer #(
    parameter int R        = 8,
    parameter int STEP_DIV = 2499999
) (
    input  logic     clk,
    input  logic     rst,
    rgb_hue_if.slave hue
);
    localparam int             DW       = (STEP_DIV > 0) ? $clog2(STEP_DIV + 1) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(STEP_DIV);
    localparam logic [DW-1:0]  DIV_ONE  = DW'(1);
    localparam logic [R-1:0]   V_LAST   = {R{1'b1}};
    localparam logic [R-1:0]   V_ONE    = R'(1);
    localparam logic [R:0]     MAX_V    = {1'b1, {R{1'b0}}};
    localparam logic [R:0]     ZERO_V   = {(R+1){1'b0}};
    localparam logic [2:0]     SEG_LAST = 3'd5;

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]    seg_q, seg_d;
    logic [R-1:0]  v_q, v_d;
    logic          wrap_evt_q, wrap_evt_d;
    logic          tick_s;

    logic [R:0]    up_s, dn_s;
    logic [R:0]    lin_r_s, lin_g_s, lin_b_s;

    logic [R:0]    duty_r_q, duty_r_d;
    logic [R:0]    duty_g_q, duty_g_d;
    logic [R:0]    duty_b_q, duty_b_d;
    logic [2:0]    segment_q, segment_d;
    logic          wrap_q, wrap_d;

`ifdef RGB_HUE_GAMMA_EN
    // Perceptual square: MAX*MAX>>R == MAX, so the result always fits in R+1 bits.
    function automatic logic [R:0] gamma(input logic [R:0] x);
        logic [2*R+1:0] prod;
        prod = {{(R+1){1'b0}}, x} * {{(R+1){1'b0}}, x};
        return (R+1)'(prod >> R);
    endfunction
`endif

    // Prescaler and wheel position; restart overrides a coincident tick.
    always_comb begin
        tick_s     = hue.en && (div_cnt_q == DIV_LAST);
        div_cnt_d  = div_cnt_q;
        seg_d      = seg_q;
        v_d        = v_q;
        wrap_evt_d = 1'b0;
        if (hue.restart) begin
            div_cnt_d = {DW{1'b0}};
            seg_d     = 3'd0;
            v_d       = {R{1'b0}};
        end else if (tick_s) begin
            div_cnt_d = {DW{1'b0}};
            if (v_q != V_LAST) begin
                v_d = v_q + V_ONE;
            end else begin
                v_d = {R{1'b0}};
                if (seg_q == SEG_LAST) begin
                    seg_d      = 3'd0;
                    wrap_evt_d = 1'b1;
                end else begin
                    seg_d = seg_q + 3'd1;
                end
            end
        end else if (hue.en) begin
            div_cnt_d = div_cnt_q + DIV_ONE;
        end else begin
            div_cnt_d = div_cnt_q;
        end
    end

    // Segment map: one channel ramps while the other two sit at MAX or 0.
    always_comb begin
        up_s = {1'b0, v_q};
        dn_s = MAX_V - up_s;
        case (seg_q)
            3'd0:    begin lin_r_s = MAX_V;  lin_g_s = up_s;   lin_b_s = ZERO_V; end
            3'd1:    begin lin_r_s = dn_s;   lin_g_s = MAX_V;  lin_b_s = ZERO_V; end
            3'd2:    begin lin_r_s = ZERO_V; lin_g_s = MAX_V;  lin_b_s = up_s;   end
            3'd3:    begin lin_r_s = ZERO_V; lin_g_s = dn_s;   lin_b_s = MAX_V;  end
            3'd4:    begin lin_r_s = up_s;   lin_g_s = ZERO_V; lin_b_s = MAX_V;  end
            3'd5:    begin lin_r_s = MAX_V;  lin_g_s = ZERO_V; lin_b_s = dn_s;   end
            default: begin lin_r_s = ZERO_V; lin_g_s = ZERO_V; lin_b_s = ZERO_V; end
        endcase
    end

    // Output register inputs; wrap follows the registered 5->0 step event.
    always_comb begin
`ifdef RGB_HUE_GAMMA_EN
        duty_r_d = gamma(lin_r_s);
        duty_g_d = gamma(lin_g_s);
        duty_b_d = gamma(lin_b_s);
`else
        duty_r_d = lin_r_s;
        duty_g_d = lin_g_s;
        duty_b_d = lin_b_s;
`endif
        segment_d = seg_q;
        wrap_d    = wrap_evt_q;
    end

    // Sequence state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q  <= {DW{1'b0}};
            seg_q      <= 3'd0;
            v_q        <= {R{1'b0}};
            wrap_evt_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            seg_q      <= seg_d;
            v_q        <= v_d;
            wrap_evt_q <= wrap_evt_d;
        end
    end

    // Output registers, one cycle behind the sequence state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_r_q  <= ZERO_V;
            duty_g_q  <= ZERO_V;
            duty_b_q  <= ZERO_V;
            segment_q <= 3'd0;
            wrap_q    <= 1'b0;
        end else begin
            duty_r_q  <= duty_r_d;
            duty_g_q  <= duty_g_d;
            duty_b_q  <= duty_b_d;
            segment_q <= segment_d;
            wrap_q    <= wrap_d;
        end
    end

    assign hue.duty_r  = duty_r_q;
    assign hue.duty_g  = duty_g_q;
    assign hue.duty_b  = duty_b_q;
    assign hue.segment = segment_q;
    assign hue.wrap    = wrap_q;
endmodule

// File: tb/tb_rgb_hue_sequencer.sv
// Bench for rgb_hue_sequencer (R=4, STEP_DIV=3): per-cycle scoreboard plus a table of checkpoints.
module tb_rgb_hue_sequencer;
    localparam int R        = 4;
    localparam int STEP_DIV = 3;
    localparam int MAX      = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rgb_hue_if #(.R(R)) hue ();

    rgb_hue_sequencer #(.R(R), .STEP_DIV(STEP_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .hue (hue)
    );

    typedef struct {
        int r;
        int g;
        int b;
        int seg;
        int wrap;
    } exp_t;

    typedef struct {
        int cycles;
        bit en;
        bit restart;
        int r;
        int g;
        int b;
        int seg;
        int wrap;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   m_div  = 0;
    int   m_seg  = 0;
    int   m_v    = 0;
    bit   m_wevt = 1'b0;

    function automatic int gm(int x);
`ifdef RGB_HUE_GAMMA_EN
        return (x * x) >> R;
`else
        return x;
`endif
    endfunction

    function automatic exp_t colour(int seg, int v, bit w);
        exp_t e;
        int up;
        int dn;
        up = v;
        dn = MAX - v;
        case (seg)
            0:       begin e.r = MAX; e.g = up;  e.b = 0;   end
            1:       begin e.r = dn;  e.g = MAX; e.b = 0;   end
            2:       begin e.r = 0;   e.g = MAX; e.b = up;  end
            3:       begin e.r = 0;   e.g = dn;  e.b = MAX; end
            4:       begin e.r = up;  e.g = 0;   e.b = MAX; end
            5:       begin e.r = MAX; e.g = 0;   e.b = dn;  end
            default: begin e.r = 0;   e.g = 0;   e.b = 0;   end
        endcase
        e.r    = gm(e.r);
        e.g    = gm(e.g);
        e.b    = gm(e.b);
        e.seg  = seg;
        e.wrap = int'(w);
        return e;
    endfunction

    task automatic cmp(string name, exp_t e);
        checks++;
        if (hue.duty_r !== (R+1)'(e.r) || hue.duty_g !== (R+1)'(e.g) || hue.duty_b !== (R+1)'(e.b) ||
            hue.segment !== 3'(e.seg) || hue.wrap !== 1'(e.wrap)) begin
            errors++;
            $display("FAIL %s @%0t: got r=%0d g=%0d b=%0d seg=%0d wrap=%0d, want r=%0d g=%0d b=%0d seg=%0d wrap=%0d",
                     name, $time, hue.duty_r, hue.duty_g, hue.duty_b, hue.segment, hue.wrap,
                     e.r, e.g, e.b, e.seg, e.wrap);
        end
    endtask

    // One clock: drive at the falling edge, predict, then compare at the next falling edge.
    task automatic cycle(bit e, bit rs);
        bit tick;
        exp_t got;
        hue.en      = e;
        hue.restart = rs;
        sb_q.push_back(colour(m_seg, m_v, m_wevt));
        tick = e && (m_div == STEP_DIV);
        if (rs) begin
            m_div = 0; m_seg = 0; m_v = 0; m_wevt = 1'b0;
        end else if (tick) begin
            m_div  = 0;
            m_wevt = (m_v == MAX - 1) && (m_seg == 5);
            if (m_v < MAX - 1) begin
                m_v++;
            end else begin
                m_v   = 0;
                m_seg = (m_seg + 1) % 6;
            end
        end else begin
            m_wevt = 1'b0;
            if (e) m_div++;
        end
        @(posedge clk);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: queue empty, got seg=%0d, want one queued entry", hue.segment);
        end else begin
            got = sb_q.pop_front();
            cmp("scoreboard", got);
        end
    endtask

    initial begin
        exp_t zero;
        exp_t first;
        zero  = '{0, 0, 0, 0, 0};
        first = '{gm(MAX), 0, 0, 0, 0};

        // Checkpoints counted in clocks from reset release (tick every 4 clocks).
        tbl.push_back('{3,   1'b0, 1'b0, gm(16), gm(0),  gm(0),  0, 0});
        tbl.push_back('{4,   1'b1, 1'b0, gm(16), gm(0),  gm(0),  0, 0});
        tbl.push_back('{1,   1'b1, 1'b0, gm(16), gm(1),  gm(0),  0, 0});
        tbl.push_back('{28,  1'b1, 1'b0, gm(16), gm(8),  gm(0),  0, 0});
        tbl.push_back('{28,  1'b1, 1'b0, gm(16), gm(15), gm(0),  0, 0});
        tbl.push_back('{4,   1'b1, 1'b0, gm(16), gm(16), gm(0),  1, 0});
        tbl.push_back('{4,   1'b1, 1'b0, gm(15), gm(16), gm(0),  1, 0});
        tbl.push_back('{315, 1'b1, 1'b0, gm(16), gm(0),  gm(1),  5, 0});
        tbl.push_back('{1,   1'b1, 1'b0, gm(16), gm(0),  gm(0),  0, 1});
        tbl.push_back('{1,   1'b1, 1'b0, gm(16), gm(0),  gm(0),  0, 0});
        tbl.push_back('{160, 1'b1, 1'b0, gm(0),  gm(16), gm(8),  2, 0});
        tbl.push_back('{20,  1'b0, 1'b0, gm(0),  gm(16), gm(8),  2, 0});
        tbl.push_back('{2,   1'b1, 1'b0, gm(0),  gm(16), gm(8),  2, 0});
        tbl.push_back('{1,   1'b1, 1'b0, gm(0),  gm(16), gm(9),  2, 0});
        tbl.push_back('{510, 1'b1, 1'b0, gm(8),  gm(0),  gm(16), 4, 0});
        tbl.push_back('{1,   1'b1, 1'b1, gm(8),  gm(0),  gm(16), 4, 0});
        tbl.push_back('{1,   1'b1, 1'b0, gm(16), gm(0),  gm(0),  0, 0});
        tbl.push_back('{208, 1'b1, 1'b0, gm(0),  gm(12), gm(16), 3, 0});

        rst         = 1'b1;
        hue.en      = 1'b0;
        hue.restart = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cmp("reset_hold", zero);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            exp_t want;
            for (int c = 0; c < tbl[i].cycles; c++) begin
                cycle(tbl[i].en, tbl[i].restart && (c == 0));
            end
            want = '{tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].seg, tbl[i].wrap};
            cmp($sformatf("vec%0d", i), want);
        end

        // Asynchronous reset in segment 3: outputs clear before any clock edge.
        #1 rst = 1'b1;
        #1 cmp("async_reset", zero);
        sb_q.delete();
        m_div = 0; m_seg = 0; m_v = 0; m_wevt = 1'b0;
        @(negedge clk);
        cmp("reset_held", zero);
        rst = 1'b0;
        cycle(1'b0, 1'b0);
        cmp("post_reset_first", first);
        cycle(1'b0, 1'b0);
        cmp("post_reset_frozen", first);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
